updown_count_ctrl: RTL and testbench

Command-driven sequencer for a multi-digit modulo-MOD up/down counter datapath built from 4-bit digit stages.
- Accepts clear, load and count-N-steps commands through a valid/ready handshake.
- Steps the digit chain one count per cycle, with ripple carry/borrow between digits.
- Reports completion, wrap-around and remaining steps to the surrounding control logic.

---
 rtl/updown_count_ctrl.sv | 163 ++++++++++++++++
 tb/tb_updown_count_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_count_ctrl.sv
// Command sequencer for an NDIG-digit modulo-MOD up/down counter with ripple carry/borrow.
// Latency: clear/load finish one cycle after accept; an N-step count finishes N cycles after accept (+ paused cycles).
// Backpressure: cmd_ready is high only in IDLE; commands offered in RUN/DONE are ignored, not queued.
module updown_count_ctrl #(
    parameter int MOD   = 10,
    parameter int NDIG  = 2,
    parameter int STEPW = 8
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [4*NDIG-1:0]   cmd_data,
    input  logic [STEPW-1:0]    cmd_steps,
    input  logic                pause,
    output logic [4*NDIG-1:0]   q,
    output logic                busy,
    output logic                done,
    output logic                wrap,
    output logic [STEPW-1:0]    steps_left
);

    localparam int          QW   = 4 * NDIG;
    localparam logic [3:0]  DMAX = 4'(MOD - 1);
    localparam logic [4:0]  MOD5 = 5'(MOD);

    localparam logic [1:0]  OP_CLR  = 2'b00;
    localparam logic [1:0]  OP_LOAD = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [QW-1:0]      q_q, q_d;
    logic               up_q, up_d;
    logic [STEPW-1:0]   steps_left_q, steps_left_d;
    logic               wrap_q, wrap_d;

    logic [QW-1:0]      load_val;
    logic [QW-1:0]      step_val;
    logic               step_carry;

    // Load value with every out-of-range digit clamped to MOD-1.
    always_comb begin : load_clamp
        load_val = '0;
        for (int i = 0; i < NDIG; i++) begin
            if ({1'b0, cmd_data[4*i +: 4]} >= MOD5) begin
                load_val[4*i +: 4] = DMAX;
            end else begin
                load_val[4*i +: 4] = cmd_data[4*i +: 4];
            end
        end
    end

    // One count step in the latched direction; carry/borrow ripples from digit 0 upward.
    always_comb begin : step_datapath
        logic       c;
        logic [3:0] d;
        c        = 1'b1;
        d        = 4'd0;
        step_val = q_q;
        for (int i = 0; i < NDIG; i++) begin
            d = q_q[4*i +: 4];
            if (c) begin
                if (up_q) begin
                    if (d == DMAX) begin
                        d = 4'd0;
                    end else begin
                        d = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        d = DMAX;
                    end else begin
                        d = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
            step_val[4*i +: 4] = d;
        end
        // Carry/borrow surviving past the top digit means the whole counter wrapped.
        step_carry = c;
    end

    // Next-state logic: command accept in IDLE, stepping in RUN, single-cycle DONE.
    always_comb begin : next_state
        state_d      = state_q;
        q_d          = q_q;
        up_d         = up_q;
        steps_left_d = steps_left_q;
        wrap_d       = wrap_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    wrap_d = 1'b0;
                    if (cmd_op == OP_CLR) begin
                        q_d          = '0;
                        steps_left_d = '0;
                        state_d      = ST_DONE;
                    end else if (cmd_op == OP_LOAD) begin
                        q_d          = load_val;
                        steps_left_d = '0;
                        state_d      = ST_DONE;
                    end else begin
                        // op[0] low selects up, high selects down.
                        up_d         = ~cmd_op[0];
                        steps_left_d = cmd_steps;
                        state_d      = (cmd_steps == '0) ? ST_DONE : ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!pause) begin
                    q_d          = step_val;
                    steps_left_d = steps_left_q - STEPW'(1);
                    if (step_carry) begin
                        wrap_d = 1'b1;
                    end
                    if (steps_left_q == STEPW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; clr clears everything immediately, even mid-count.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= ST_IDLE;
            q_q          <= '0;
            up_q         <= 1'b1;
            steps_left_q <= '0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            q_q          <= q_d;
            up_q         <= up_d;
            steps_left_q <= steps_left_d;
            wrap_q       <= wrap_d;
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign q          = q_q;
    assign wrap       = wrap_q;
    assign steps_left = steps_left_q;

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Testbench for updown_count_ctrl: directed scenarios plus random commands against a value-level model.
// Latency: model advances per accepted command and per unpaused RUN cycle.
// Backpressure: exercises pause and cmd_valid held through RUN/DONE.
module tb_updown_count_ctrl;

    localparam int MOD   = 10;
    localparam int NDIG  = 2;
    localparam int STEPW = 8;
    localparam int QW    = 4 * NDIG;
    localparam int MODN  = MOD ** NDIG;

    logic              clk;
    logic              clr;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [QW-1:0]     cmd_data;
    logic [STEPW-1:0]  cmd_steps;
    logic              pause;
    logic [QW-1:0]     q;
    logic              busy;
    logic              done;
    logic              wrap;
    logic [STEPW-1:0]  steps_left;

    updown_count_ctrl #(.MOD(MOD), .NDIG(NDIG), .STEPW(STEPW)) dut (
        .clk        (clk),
        .clr        (clr),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_steps  (cmd_steps),
        .pause      (pause),
        .q          (q),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap),
        .steps_left (steps_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: counter held as a plain integer in 0..MODN-1.
    int m_val  = 0;
    bit m_wrap = 0;
    bit m_up   = 1;
    int m_left = 0;
    int m_n    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_q(input int v);
        logic [31:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(t % MOD);
            t = t / MOD;
        end
        return r;
    endfunction

    function automatic int sat_val(input logic [QW-1:0] data);
        int v, w, f;
        v = 0;
        w = 1;
        for (int i = 0; i < NDIG; i++) begin
            f = int'(data[4*i +: 4]);
            if (f > MOD - 1) f = MOD - 1;
            v = v + f * w;
            w = w * MOD;
        end
        return v;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_rdy"},  32'(cmd_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_q"},    32'(q), to_q(m_val));
        chk({tag, "_wrap"}, 32'(wrap), 32'(m_wrap));
        chk({tag, "_left"}, 32'(steps_left), 32'd0);
    endtask

    // Present a command in IDLE; it is accepted at the next edge.
    task automatic issue(input logic [1:0] op, input logic [QW-1:0] data,
                         input int steps, input bit hold);
        cmd_op    = op;
        cmd_data  = data;
        cmd_steps = STEPW'(steps);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
        m_wrap = 0;
        m_left = 0;
        m_n    = 0;
        case (op)
            2'b00: m_val = 0;
            2'b01: m_val = sat_val(data);
            default: begin
                m_up   = (op == 2'b10);
                m_left = steps;
                m_n    = steps;
            end
        endcase
    endtask

    // Follow a command from just after its accept edge to the following IDLE cycle.
    // mode 0: no pause, 1: random pause, 2: pause 3 cycles after the 2nd step.
    task automatic finish(input int mode, output int cyc);
        int  paused;
        bit  p;
        cyc    = 0;
        paused = 0;
        while (m_left > 0) begin
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_rdy",  32'(cmd_ready), 32'd0);
            chk("run_done", 32'(done), 32'd0);
            chk("run_q",    32'(q), to_q(m_val));
            chk("run_left", 32'(steps_left), 32'(m_left));
            chk("run_wrap", 32'(wrap), 32'(m_wrap));
            case (mode)
                1:       p = (paused < 6) && ($urandom_range(0, 3) == 0);
                2:       p = ((m_n - m_left) == 2) && (paused < 3);
                default: p = 0;
            endcase
            pause = p;
            @(posedge clk);
            #1;
            cyc++;
            if (p) begin
                paused++;
            end else begin
                if (m_up) begin
                    if (m_val == MODN - 1) m_wrap = 1;
                    m_val = (m_val + 1) % MODN;
                end else begin
                    if (m_val == 0) m_wrap = 1;
                    m_val = (m_val + MODN - 1) % MODN;
                end
                m_left--;
            end
        end
        chk("lat", 32'(cyc), 32'(m_n + paused));
        chk("dn_done", 32'(done), 32'd1);
        chk("dn_busy", 32'(busy), 32'd1);
        chk("dn_rdy",  32'(cmd_ready), 32'd0);
        chk("dn_q",    32'(q), to_q(m_val));
        chk("dn_wrap", 32'(wrap), 32'(m_wrap));
        chk("dn_left", 32'(steps_left), 32'd0);
        // pause has no effect outside RUN
        pause = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        pause = 1'b0;
        check_idle("idle");
    endtask

    int cyc;
    int rop;

    initial begin
        clr       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = '0;
        cmd_steps = '0;
        pause     = 1'b0;
        #2;
        check_idle("rst");
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a long count.
        issue(2'b01, 8'h00, 0, 0);
        finish(0, cyc);
        issue(2'b10, '0, 20, 0);
        repeat (5) @(posedge clk);
        #3;
        clr = 1'b0;
        #1;
        m_val  = 0;
        m_wrap = 0;
        check_idle("arst");
        #2;
        clr = 1'b1;
        @(posedge clk);
        #1;
        check_idle("post_rst");

        // Load and clamped load; next command accepted two edges after a load.
        issue(2'b01, 8'h47, 0, 0);
        chk("load47", 32'(q), 32'h47);
        finish(0, cyc);
        issue(2'b01, 8'hAF, 0, 0);
        chk("loadAF", 32'(q), 32'h99);
        finish(0, cyc);

        // Up across the top boundary.
        issue(2'b01, 8'h97, 0, 0);
        finish(0, cyc);
        issue(2'b10, '0, 5, 0);
        finish(0, cyc);
        chk("up5_q",    32'(q), 32'h02);
        chk("up5_wrap", 32'(wrap), 32'd1);

        // Down across zero, then a new command clears wrap.
        issue(2'b01, 8'h01, 0, 0);
        finish(0, cyc);
        issue(2'b11, '0, 3, 0);
        finish(0, cyc);
        chk("dn3_q",    32'(q), 32'h98);
        chk("dn3_wrap", 32'(wrap), 32'd1);
        issue(2'b10, '0, 1, 0);
        finish(0, cyc);
        chk("up1_q",    32'(q), 32'h99);
        chk("up1_wrap", 32'(wrap), 32'd0);

        // Pause for 3 cycles after the 2nd step.
        issue(2'b00, '0, 0, 0);
        finish(0, cyc);
        issue(2'b10, '0, 4, 0);
        finish(2, cyc);
        chk("pause_lat", 32'(cyc), 32'd7);
        chk("pause_q",   32'(q), 32'h04);

        // Zero-step count.
        issue(2'b10, '0, 0, 0);
        finish(0, cyc);
        chk("zero_q", 32'(q), 32'h04);

        // cmd_valid held through RUN/DONE: second acceptance only from IDLE.
        issue(2'b01, 8'h10, 0, 0);
        finish(0, cyc);
        issue(2'b10, '0, 3, 1);
        finish(0, cyc);
        issue(2'b10, '0, 3, 0);
        finish(0, cyc);
        chk("hold_q", 32'(q), 32'h16);

        // Random commands.
        for (int n = 0; n < 150; n++) begin
            rop = $urandom_range(0, 9);
            if (rop == 0)      issue(2'b00, '0, 0, 0);
            else if (rop <= 2) issue(2'b01, QW'($urandom), 0, 0);
            else               issue((rop < 7) ? 2'b10 : 2'b11, '0, $urandom_range(0, 25), 0);
            finish(1, cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
